// File: rtl/fir_fp16_mac_datapath.sv
// fir_fp16_mac_datapath
//   Arithmetic datapath of the FIR core: three independent single-cycle
//   registered stages sharing one clock and one asynchronous active-low reset.
//     converter : signed Q1.15 sample      -> fp16
//     multiplier: fp16 a * fp16 b          -> fp16
//     adder     : fp16 acc_in + multiplier_out -> fp16
//   All stages round to nearest even, flush subnormal inputs/results to
//   signed zero, saturate overflow to signed infinity and return canonical
//   NaN 0x7E00 for NaN inputs, inf*0 and inf+(-inf).
//
// Ports
//   clk            system clock, rising-edge active
//   rst            asynchronous reset, active low; clears all outputs
//   fixed_in       Q1.15 sample             float_out  fp16(fixed_in)
//   a, b           fp16 operands            result     fp16(a*b)
//   acc_in         fp16 accumulator value
//   multiplier_out fp16 product to add      acc_out    fp16(acc_in+multiplier_out)
module fir_fp16_mac_datapath #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fixed_in,
    output logic [DW-1:0] float_out,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    input  logic [DW-1:0] acc_in,
    input  logic [DW-1:0] multiplier_out,
    output logic [DW-1:0] acc_out
);

    localparam logic [15:0] QNAN = 16'h7E00;

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    logic [15:0] cv_mag;
    logic [15:0] cv_norm;
    logic [3:0]  cv_p;
    logic        cv_up;
    logic [11:0] cv_sig;
    logic [4:0]  cv_exp;
    logic [15:0] cv_next;

    always_comb begin
        // |0x8000| = 32768 still fits a 16-bit unsigned magnitude
        cv_mag = fixed_in[15] ? (~fixed_in + 16'd1) : fixed_in;
        cv_p   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (cv_mag[i]) cv_p = 4'(i);
        end
        // leading one moved to bit 15; value = mag * 2^-15 so biased exp = p
        cv_norm = cv_mag << (4'd15 - cv_p);
        cv_up   = cv_norm[4] & ((|cv_norm[3:0]) | cv_norm[5]);
        cv_sig  = {1'b0, cv_norm[15:5]} + {11'd0, cv_up};
        cv_exp  = {1'b0, cv_p} + {4'd0, cv_sig[11]};
        if (!cv_norm[15] || cv_p == 4'd0) begin
            // zero input, or 2^-15 which lies below the normal range
            cv_next = {fixed_in[15], 15'd0};
        end else begin
            cv_next = {fixed_in[15], cv_exp, cv_sig[11] ? cv_sig[10:1] : cv_sig[9:0]};
        end
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    logic [4:0]        ma_e, mb_e;
    logic              ma_nan, ma_inf, ma_zero;
    logic              mb_nan, mb_inf, mb_zero;
    logic              m_sign;
    logic [21:0]       m_prod;
    logic              m_hi;
    logic [10:0]       m_sig;
    logic              m_g, m_st, m_up;
    logic [11:0]       m_sig_r;
    logic signed [7:0] m_exp;
    logic [15:0]       m_next;

    always_comb begin
        ma_e    = a[14:10];
        mb_e    = b[14:10];
        ma_nan  = (&ma_e) & (|a[9:0]);
        ma_inf  = (&ma_e) & ~(|a[9:0]);
        ma_zero = (ma_e == 5'd0);
        mb_nan  = (&mb_e) & (|b[9:0]);
        mb_inf  = (&mb_e) & ~(|b[9:0]);
        mb_zero = (mb_e == 5'd0);
        m_sign  = a[15] ^ b[15];

        m_prod  = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        m_hi    = m_prod[21];
        m_sig   = m_hi ? m_prod[21:11] : m_prod[20:10];
        m_g     = m_hi ? m_prod[10] : m_prod[9];
        m_st    = m_hi ? (|m_prod[9:0]) : (|m_prod[8:0]);
        m_up    = m_g & (m_st | m_sig[0]);
        m_sig_r = {1'b0, m_sig} + {11'd0, m_up};
        m_exp   = $signed({3'd0, ma_e}) + $signed({3'd0, mb_e}) - 8'sd15
                + $signed({7'd0, m_hi}) + $signed({7'd0, m_sig_r[11]});

        m_next = {m_sign, m_exp[4:0], m_sig_r[11] ? m_sig_r[10:1] : m_sig_r[9:0]};
        if (ma_nan || mb_nan || (ma_inf && mb_zero) || (mb_inf && ma_zero)) begin
            m_next = QNAN;
        end else if (ma_inf || mb_inf) begin
            m_next = {m_sign, 5'h1F, 10'd0};
        end else if (ma_zero || mb_zero) begin
            m_next = {m_sign, 15'd0};
        end else if (m_exp >= 8'sd31) begin
            m_next = {m_sign, 5'h1F, 10'd0};
        end else if (m_exp <= 8'sd0) begin
            m_next = {m_sign, 15'd0};
        end
    end

    // ------------------------------------------------------------------
    // Adder
    // ------------------------------------------------------------------
    logic              x_nan, x_inf, x_zero;
    logic              y_nan, y_inf, y_zero;
    logic              ad_swap, ad_sign, ad_sub;
    logic [14:0]       ad_big, ad_small;
    logic [4:0]        ad_d;
    logic [25:0]       ad_tmp;
    logic [12:0]       ad_al;
    logic              ad_st;
    logic [14:0]       ad_sum;
    logic [3:0]        ad_lp, ad_sh;
    logic [13:0]       ad_n;
    logic              ad_up;
    logic [11:0]       ad_sig_r;
    logic signed [7:0] ad_exp_base, ad_exp;
    logic [15:0]       ad_next;

    always_comb begin
        x_nan  = (&acc_in[14:10]) & (|acc_in[9:0]);
        x_inf  = (&acc_in[14:10]) & ~(|acc_in[9:0]);
        x_zero = (acc_in[14:10] == 5'd0);
        y_nan  = (&multiplier_out[14:10]) & (|multiplier_out[9:0]);
        y_inf  = (&multiplier_out[14:10]) & ~(|multiplier_out[9:0]);
        y_zero = (multiplier_out[14:10] == 5'd0);

        ad_swap  = multiplier_out[14:0] > acc_in[14:0];
        ad_big   = ad_swap ? multiplier_out[14:0] : acc_in[14:0];
        ad_small = ad_swap ? acc_in[14:0] : multiplier_out[14:0];
        ad_sign  = ad_swap ? multiplier_out[15] : acc_in[15];
        ad_sub   = acc_in[15] ^ multiplier_out[15];
        ad_d     = ad_big[14:10] - ad_small[14:10];

        // Smaller significand aligned to {sig, guard, round}; everything
        // shifted past the round bit collapses into a separate sticky bit.
        ad_tmp = {1'b1, ad_small[9:0], 15'd0} >> ad_d;
        if (ad_d > 5'd13) begin
            ad_al = '0;
            ad_st = 1'b1;
        end else begin
            ad_al = ad_tmp[25:13];
            ad_st = |ad_tmp[12:0];
        end

        ad_sum = ad_sub ? ({2'b01, ad_big[9:0], 3'd0} - {1'b0, ad_al, ad_st})
                        : ({2'b01, ad_big[9:0], 3'd0} + {1'b0, ad_al, ad_st});

        ad_lp = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (ad_sum[i]) ad_lp = 4'(i);
        end
        ad_sh = 4'd13 - ad_lp;

        // Normalise so the leading one sits at bit 13 of ad_n
        if (ad_lp == 4'd14) begin
            ad_n        = {ad_sum[14:2], ad_sum[1] | ad_sum[0]};
            ad_exp_base = $signed({3'd0, ad_big[14:10]}) + 8'sd1;
        end else begin
            ad_n        = ad_sum[13:0] << ad_sh;
            ad_exp_base = $signed({3'd0, ad_big[14:10]}) - $signed({4'd0, ad_sh});
        end
        ad_up    = ad_n[2] & ((|ad_n[1:0]) | ad_n[3]);
        ad_sig_r = {1'b0, ad_n[13:3]} + {11'd0, ad_up};
        ad_exp   = ad_exp_base + $signed({7'd0, ad_sig_r[11]});

        ad_next = {ad_sign, ad_exp[4:0], ad_sig_r[11] ? ad_sig_r[10:1] : ad_sig_r[9:0]};
        if (x_nan || y_nan || (x_inf && y_inf && ad_sub)) begin
            ad_next = QNAN;
        end else if (x_inf) begin
            ad_next = acc_in;
        end else if (y_inf) begin
            ad_next = multiplier_out;
        end else if (x_zero && y_zero) begin
            ad_next = {acc_in[15] & multiplier_out[15], 15'd0};
        end else if (x_zero) begin
            ad_next = multiplier_out;
        end else if (y_zero) begin
            ad_next = acc_in;
        end else if (ad_sum == 15'd0) begin
            ad_next = '0;
        end else if (ad_exp >= 8'sd31) begin
            ad_next = {ad_sign, 5'h1F, 10'd0};
        end else if (ad_exp <= 8'sd0) begin
            ad_next = {ad_sign, 15'd0};
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            float_out <= '0;
            result    <= '0;
            acc_out   <= '0;
        end else begin
            float_out <= cv_next;
            result    <= m_next;
            acc_out   <= ad_next;
        end
    end

endmodule

// File: tb/tb_fir_fp16_mac_datapath.sv
// Self-checking bench for fir_fp16_mac_datapath. Expected values come from
// directed constants and from a real-arithmetic fp16 reference model.
module tb_fir_fp16_mac_datapath;

    logic        clk;
    logic        rst;
    logic [15:0] fixed_in, a, b, acc_in, multiplier_out;
    logic [15:0] float_out, result, acc_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] q_conv[$];
    logic [15:0] q_mul[$];
    logic [15:0] q_add[$];

    fir_fp16_mac_datapath #(.DW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fixed_in       (fixed_in),
        .float_out      (float_out),
        .a              (a),
        .b              (b),
        .result         (result),
        .acc_in         (acc_in),
        .multiplier_out (multiplier_out),
        .acc_out        (acc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic real pow2(int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic bit f_nan(logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    function automatic bit f_inf(logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
    endfunction

    function automatic bit f_zero(logic [15:0] h);
        return h[14:10] == 5'd0;
    endfunction

    function automatic real f_mag(logic [15:0] h);
        if (h[14:10] == 5'd0) return 0.0;
        return (1024.0 + real'(int'(h[9:0]))) * pow2(int'(h[14:10]) - 25);
    endfunction

    // Round a positive real to fp16 (RNE), then flush / saturate
    function automatic logic [15:0] round_fp16(bit s, real m_in);
        real    m = m_in;
        real    sc, fl;
        int     e = 0;
        int     be;
        longint ip;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sc = m * 1024.0;
        fl = $floor(sc);
        ip = longint'(fl);
        if ((sc - fl) > 0.5 || ((sc - fl) == 0.5 && ip[0])) ip++;
        if (ip == 2048) begin ip = 1024; e++; end
        be = e + 15;
        if (be >= 31) return {s, 5'h1F, 10'd0};
        if (be <= 0)  return {s, 15'd0};
        return {s, 5'(be), 10'(ip)};
    endfunction

    function automatic logic [15:0] model_conv(logic [15:0] x);
        real v;
        if (x == 16'h0000) return 16'h0000;
        v = real'(int'($signed(x))) / 32768.0;
        return round_fp16(x[15], (v < 0.0) ? -v : v);
    endfunction

    function automatic logic [15:0] model_mul(logic [15:0] x, logic [15:0] y);
        bit s = x[15] ^ y[15];
        if (f_nan(x) || f_nan(y)) return 16'h7E00;
        if ((f_inf(x) && f_zero(y)) || (f_inf(y) && f_zero(x))) return 16'h7E00;
        if (f_inf(x) || f_inf(y)) return {s, 5'h1F, 10'd0};
        if (f_zero(x) || f_zero(y)) return {s, 15'd0};
        return round_fp16(s, f_mag(x) * f_mag(y));
    endfunction

    function automatic logic [15:0] model_add(logic [15:0] x, logic [15:0] y);
        real vx, vy, sum;
        if (f_nan(x) || f_nan(y)) return 16'h7E00;
        if (f_inf(x) && f_inf(y) && (x[15] != y[15])) return 16'h7E00;
        if (f_inf(x)) return x;
        if (f_inf(y)) return y;
        if (f_zero(x) && f_zero(y)) return {x[15] & y[15], 15'd0};
        vx  = x[15] ? -f_mag(x) : f_mag(x);
        vy  = y[15] ? -f_mag(y) : f_mag(y);
        sum = vx + vy;
        if (sum == 0.0) return 16'h0000;
        return round_fp16(sum < 0.0, (sum < 0.0) ? -sum : sum);
    endfunction

    function automatic logic [15:0] rand_fp16(bit narrow);
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 5))
                0: r = 16'h0000;
                1: r = 16'h8000;
                2: r = 16'h7C00;
                3: r = 16'hFC00;
                4: r = 16'h7E01;
                default: r[14:10] = 5'd0;
            endcase
        end else if (narrow) begin
            r[14:10] = 5'($urandom_range(9, 21));
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        int e;
        fixed_in = 16'($urandom);
        a        = rand_fp16($urandom_range(0, 1) == 1);
        b        = rand_fp16($urandom_range(0, 1) == 1);
        acc_in   = rand_fp16(1'b0);
        multiplier_out = rand_fp16(1'b0);
        if ($urandom_range(0, 1) == 1 && acc_in[14:10] != 5'd0 && acc_in[14:10] != 5'h1F) begin
            e = int'(acc_in[14:10]) + int'($urandom_range(0, 4)) - 2;
            if (e < 1)  e = 1;
            if (e > 30) e = 30;
            multiplier_out[14:10] = 5'(e);
        end
        q_conv.push_back(model_conv(fixed_in));
        q_mul.push_back(model_mul(a, b));
        q_add.push_back(model_add(acc_in, multiplier_out));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] exp_v;
        rst = 1'b1;
        fixed_in = 16'h1234; a = 16'h3C00; b = 16'h4000;
        acc_in = 16'h3C00; multiplier_out = 16'h3C00;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (float_out !== 16'h0000 || result !== 16'h0000 || acc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async_pre_clk got conv=%h mul=%h add=%h exp=0000", float_out, result, acc_out);
        end
        repeat (2) step();
        n_checks++;
        if (float_out !== 16'h0000 || result !== 16'h0000 || acc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_held got conv=%h mul=%h add=%h exp=0000", float_out, result, acc_out);
        end
        rst = 1'b1;
        fixed_in = 16'h4000;
        q_conv.push_back(16'h3800);
        step();
        exp_v = q_conv.pop_front();
        n_checks++;
        if (float_out !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release_conv got=%h exp=%h", float_out, exp_v);
        end
    endtask

    task automatic test_converter();
        logic [15:0] vin [8] = '{16'h8000, 16'h7FFF, 16'h0001, 16'hC000,
                                 16'h0000, 16'h0002, 16'hFFFF, 16'h4000};
        logic [15:0] vexp[8] = '{16'hBC00, 16'h3C00, 16'h0000, 16'hB800,
                                 16'h0000, 16'h0400, 16'h8000, 16'h3800};
        logic [15:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            fixed_in = vin[i];
            q_conv.push_back(vexp[i]);
            step();
            exp_v = q_conv.pop_front();
            n_checks++;
            if (float_out !== exp_v) begin
                n_fail++;
                $display("FAIL conv in=%h got=%h exp=%h", vin[i], float_out, exp_v);
            end
        end
    endtask

    task automatic test_multiplier();
        logic [15:0] va  [7] = '{16'h3E00, 16'hBC00, 16'h7BFF, 16'h7C00, 16'h8000, 16'h0400, 16'hFC00};
        logic [15:0] vb  [7] = '{16'h4000, 16'h3800, 16'h4000, 16'h0000, 16'h3C00, 16'h3800, 16'h3C00};
        logic [15:0] vexp[7] = '{16'h4200, 16'hB800, 16'h7C00, 16'h7E00, 16'h8000, 16'h0000, 16'hFC00};
        logic [15:0] exp_v;
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            q_mul.push_back(vexp[i]);
            step();
            exp_v = q_mul.pop_front();
            n_checks++;
            if (result !== exp_v) begin
                n_fail++;
                $display("FAIL mul a=%h b=%h got=%h exp=%h", va[i], vb[i], result, exp_v);
            end
        end
    endtask

    task automatic test_adder();
        // 3.0 + (-0.5) = 2.5 -> 0x4100; the 0x1000 cases are exact RNE ties
        logic [15:0] vx  [8] = '{16'h3C00, 16'h3C00, 16'h4200, 16'h7C00,
                                 16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF};
        logic [15:0] vy  [8] = '{16'h3C00, 16'hBC00, 16'hB800, 16'hFC00,
                                 16'h1400, 16'h1000, 16'h1000, 16'h7BFF};
        logic [15:0] vexp[8] = '{16'h4000, 16'h0000, 16'h4100, 16'h7E00,
                                 16'h3C01, 16'h3C00, 16'h3C02, 16'h7C00};
        logic [15:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            acc_in = vx[i];
            multiplier_out = vy[i];
            q_add.push_back(vexp[i]);
            step();
            exp_v = q_add.pop_front();
            n_checks++;
            if (acc_out !== exp_v) begin
                n_fail++;
                $display("FAIL add x=%h y=%h got=%h exp=%h", vx[i], vy[i], acc_out, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp_v;
        fixed_in = 16'h2000; a = 16'h3E00; b = 16'h4000;
        acc_in = 16'h3C00; multiplier_out = 16'h3C00;
        q_conv.push_back(model_conv(fixed_in));
        step();
        exp_v = q_conv.pop_front();
        n_checks++;
        if (float_out !== exp_v) begin
            n_fail++;
            $display("FAIL midop_pre_conv got=%h exp=%h", float_out, exp_v);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (float_out !== 16'h0000 || result !== 16'h0000 || acc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_async_clear got conv=%h mul=%h add=%h exp=0000", float_out, result, acc_out);
        end
        step();
        n_checks++;
        if (float_out !== 16'h0000 || result !== 16'h0000 || acc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_held got conv=%h mul=%h add=%h exp=0000", float_out, result, acc_out);
        end
        rst = 1'b1;
        q_mul.push_back(16'h4200);
        step();
        exp_v = q_mul.pop_front();
        n_checks++;
        if (result !== exp_v) begin
            n_fail++;
            $display("FAIL midop_release_mul got=%h exp=%h", result, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ec, em, ea;
        for (int i = 0; i < 8; i++) begin
            drive_random();
            step();
            ec = q_conv.pop_front();
            em = q_mul.pop_front();
            ea = q_add.pop_front();
            n_checks++;
            if (float_out !== ec) begin
                n_fail++;
                $display("FAIL b2b_conv cyc=%0d got=%h exp=%h", i, float_out, ec);
            end
            n_checks++;
            if (result !== em) begin
                n_fail++;
                $display("FAIL b2b_mul cyc=%0d got=%h exp=%h", i, result, em);
            end
            n_checks++;
            if (acc_out !== ea) begin
                n_fail++;
                $display("FAIL b2b_add cyc=%0d got=%h exp=%h", i, acc_out, ea);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ec, em, ea;
        logic [15:0] pf, pa, pb, px, py;
        for (int i = 0; i < 10000; i++) begin
            drive_random();
            pf = fixed_in; pa = a; pb = b; px = acc_in; py = multiplier_out;
            step();
            ec = q_conv.pop_front();
            em = q_mul.pop_front();
            ea = q_add.pop_front();
            n_checks++;
            if (float_out !== ec) begin
                n_fail++;
                $display("FAIL rand_conv in=%h got=%h exp=%h", pf, float_out, ec);
            end
            n_checks++;
            if (result !== em) begin
                n_fail++;
                $display("FAIL rand_mul a=%h b=%h got=%h exp=%h", pa, pb, result, em);
            end
            n_checks++;
            if (acc_out !== ea) begin
                n_fail++;
                $display("FAIL rand_add x=%h y=%h got=%h exp=%h", px, py, acc_out, ea);
            end
        end
    endtask

    initial begin
        test_reset();
        test_converter();
        test_multiplier();
        test_adder();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
